// File: rtl/act_sigmoid_bp.sv
// Backward pass of the LSTM sigmoid gate: delta = dL/dy * y * (1 - y), bias-gradient
// accumulation and per-element gradient/error products. Define SIGMOID_BP_SAT_EN to saturate results.
module act_sigmoid_bp #(
    parameter int WIDTH = 24,
    parameter int FRAC  = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_act,
    input  logic [WIDTH-1:0] i_dout,
    input  logic             i_clr,
    input  logic             i_valid,
    input  logic             i_last,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_h,
    input  logic [WIDTH-1:0] i_w,
    input  logic [WIDTH-1:0] i_u,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_delta,
    output logic             o_delta_vld,
    output logic [WIDTH-1:0] o_db,
    output logic [WIDTH-1:0] o_dw,
    output logic [WIDTH-1:0] o_du,
    output logic [WIDTH-1:0] o_dx,
    output logic [WIDTH-1:0] o_dh,
    output logic             o_valid,
    output logic             o_done
);

    typedef enum logic [2:0] {IDLE, PROD, DELT, STRM, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
    localparam logic signed [2*WIDTH-1:0] MAX_V = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] MIN_V = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    function automatic logic signed [2*WIDTH-1:0] sext(input logic [WIDTH-1:0] a);
        return $signed({{WIDTH{a[WIDTH-1]}}, a});
    endfunction

    // Full-width signed product, arithmetic shift rounds toward -inf.
    function automatic logic signed [2*WIDTH-1:0] mul_shift(input logic [WIDTH-1:0] a,
                                                           input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        p = sext(a) * sext(b);
        return p >>> FRAC;
    endfunction

    function automatic logic [WIDTH-1:0] reduce(input logic signed [2*WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
`ifdef SIGMOID_BP_SAT_EN
        if (v > MAX_V)      r = MAX_V[WIDTH-1:0];
        else if (v < MIN_V) r = MIN_V[WIDTH-1:0];
        else                r = v[WIDTH-1:0];
`else
        r = v[WIDTH-1:0];
`endif
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] act_q, act_d, dout_q, dout_d, s_q, s_d, delta_q, delta_d, db_q, db_d;
    logic [WIDTH-1:0] dw_q, dw_d, du_q, du_d, dx_q, dx_d, dh_q, dh_d;
    logic             delta_vld_q, delta_vld_d, valid_q, valid_d, done_q, done_d;

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        dout_d      = dout_q;
        s_d         = s_q;
        delta_d     = delta_q;
        db_d        = db_q;
        dw_d        = dw_q;
        du_d        = du_q;
        dx_d        = dx_q;
        dh_d        = dh_q;
        delta_vld_d = 1'b0;
        valid_d     = 1'b0;
        done_d      = 1'b0;
        if (i_clr) db_d = '0;
        case (state_q)
            IDLE: if (i_start) begin
                act_d   = i_act;
                dout_d  = i_dout;
                state_d = PROD;
            end
            PROD: begin
                s_d     = reduce(mul_shift(act_q, ONE - act_q));
                state_d = DELT;
            end
            DELT: begin
                delta_d     = reduce(mul_shift(dout_q, s_q));
                delta_vld_d = 1'b1;
                // Clear-then-add when the clear lands on the accumulate cycle.
                db_d        = i_clr ? delta_d : reduce(sext(db_q) + sext(delta_d));
                state_d     = STRM;
            end
            STRM: if (i_valid) begin
                dw_d    = reduce(mul_shift(delta_q, i_x));
                du_d    = reduce(mul_shift(delta_q, i_h));
                dx_d    = reduce(mul_shift(delta_q, i_w));
                dh_d    = reduce(mul_shift(delta_q, i_u));
                valid_d = 1'b1;
                if (i_last) state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            act_q       <= '0;
            dout_q      <= '0;
            s_q         <= '0;
            delta_q     <= '0;
            db_q        <= '0;
            dw_q        <= '0;
            du_q        <= '0;
            dx_q        <= '0;
            dh_q        <= '0;
            delta_vld_q <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            dout_q      <= dout_d;
            s_q         <= s_d;
            delta_q     <= delta_d;
            db_q        <= db_d;
            dw_q        <= dw_d;
            du_q        <= du_d;
            dx_q        <= dx_d;
            dh_q        <= dh_d;
            delta_vld_q <= delta_vld_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

    assign o_busy      = (state_q != IDLE);
    assign o_delta     = delta_q;
    assign o_delta_vld = delta_vld_q;
    assign o_db        = db_q;
    assign o_dw        = dw_q;
    assign o_du        = du_q;
    assign o_dx        = dx_q;
    assign o_dh        = dh_q;
    assign o_valid     = valid_q;
    assign o_done      = done_q;

endmodule
